pwm_led_bank: RTL and testbench
===============================

Name: pwm_led_bank

Overview:
- Parametrised N-channel PWM LED driver on the 8-bit-style peripheral bus: byte-wide register reads and writes, one-cycle read latency.
- Generalises the fixed 3-LED 8-bit dimmer:
  - configurable channel count and duty width;
  - programmable prescaler;
  - global enable and polarity control;
  - glitch-free duty updates latched at period start.
- Sits on the CPU peripheral bus next to the other memory-mapped I/O blocks and drives board LEDs directly.

Parameters:
- NCH, 3, number of PWM channels (1..6).
- WIDTH, 8, duty/counter width in bits and bus data width (4..8).
- PRESC_W, 8, prescaler register width.

Ports:
- clk  in  1  system clock
- rst_n  in  1  asynchronous active-low reset
- rd_en  in  1  read strobe, single cycle
- addr  in  5  byte address; registers on 4-byte boundaries
- rd_data  out  WIDTH  read data
- rd_valid  out  1  one-cycle pulse, read data valid
- wr_en  in  1  write strobe, single cycle
- wr_data  in  WIDTH  write data
- led  out  NCH  PWM outputs, bit i = channel i

Behaviour:
- Reset: one clock, reset asynchronous and active-low; rst_n low asynchronously clears all state.
  - Duty shadow and active registers = 0; ctrl = 0x01 (enabled, non-inverted); presc = 0.
  - Prescaler count = 0, period counter = 0.
  - led = 0, rd_data = 0, rd_valid = 0.
- Register map:
  - 0x00 + 4*i: duty of channel i, for i < NCH.
  - 0x18: ctrl. bit0 = EN, bit1 = INV, other bits read 0.
  - 0x1C: presc, low PRESC_W bits; truncated to bus width if PRESC_W > WIDTH.
  - Unmapped or out-of-range channel addresses: reads return 0, writes ignored.
- Reads:
  - rd_en at cycle t -> rd_data and rd_valid=1 at t+1; rd_valid=0 otherwise; rd_data holds its last value.
  - Duty reads return the shadow (last written) value, not the active one.
- Writes: take effect in the shadow or ctrl/presc register at the next edge.
  - Simultaneous rd_en and wr_en to the same address: read returns the pre-write value.
- Tick: prescaler counts 0..presc, then wraps; tick asserts on the wrap. presc=0 gives a tick every cycle.
- Period counter:
  - WIDTH bits, increments on each tick and wraps 2^WIDTH-1 -> 0.
  - Period length = 2^WIDTH ticks.
  - Period start = the tick on which the counter becomes 0.
- Duty update: at period start each active duty loads its shadow, so there are no mid-period glitches.
  - A write landing in the same cycle as period start is taken at the following period start.
- Output, registered, one cycle after counter update:
  - raw_i = (cnt < active_duty_i), except active_duty_i = 2^WIDTH-1, which forces raw_i = 1 (full on).
  - Duty 0 gives constant off.
  - led_i = EN ? (raw_i XOR INV) : INV.
- ctrl and presc changes act immediately; the counter is not restarted.
  - Writing presc below the current prescaler count forces a wrap on the next cycle.
- EN=0 freezes the prescaler and counter; re-enable resumes from the frozen count.

Optional Feature:
- Macro PWM_LED_FADE_EN.
- When defined:
  - At each period start, every active duty steps by +1 or -1 toward its shadow (target) instead of loading it.
  - Equal values mean no change; a full sweep 0 -> 255 takes 255 periods.
  - The extra read-only register 0x14 returns a bitmask of channels still fading (active != shadow); it reads 0 when idle.
  - Requires NCH <= 5.
- When not defined:
  - Immediate shadow-to-active load at period start as above.
  - 0x14 is a normal duty address when NCH = 6, otherwise unmapped.

Test Plan:
- Reset state: rst_n low mid-period with duty 0x80 active -> led=0 asynchronously; after release all duty reads = 0, ctrl read = 0x01, and the read at t produces rd_valid pulse at t+1 only.
- Basic PWM (WIDTH=8, presc=0): write duty0=0x40 -> from the next period start led[0] high for exactly 64 of every 256 cycles; duty=0 -> never high; duty=0xFF -> always high.
- Prescaler: presc=3, duty1=0x80 -> period = 1024 cycles, led[1] high for 512 cycles.
- Glitch-free update: write duty0 0x40 -> 0x10 at counter 0x20 -> current period keeps 64-cycle high; the next period has 16 high cycles; readback returns 0x10 immediately.
- Ctrl: INV=1, duty0=0x40 -> led[0] low for 64 of 256 cycles; EN=0 -> led = all 1 (INV) with counter frozen; re-enable resumes at the same count; unmapped read 0x10 (NCH=3) -> 0.
- PWM_LED_FADE_EN: duty0 0 -> write 0x04 -> high time 1, 2, 3, 4 over the next four periods; 0x14 reads 0x01 until done, then 0x00.

Source files
------------

// File: rtl/pwm_led_bank.sv
// pwm_led_bank: N-channel PWM LED driver on a byte-wide register bus with prescaler and period-latched duty.
// Optional PWM_LED_FADE_EN: active duties step one count per period toward the written value (NCH <= 5).
module pwm_led_bank #(
  parameter int NCH     = 3,
  parameter int WIDTH   = 8,
  parameter int PRESC_W = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             rd_en,
  input  logic [4:0]       addr,
  output logic [WIDTH-1:0] rd_data,
  output logic             rd_valid,
  input  logic             wr_en,
  input  logic [WIDTH-1:0] wr_data,
  output logic [NCH-1:0]   led
);
  localparam logic [WIDTH-1:0] FULL      = '1;
  localparam logic [2:0]       IDX_CTRL  = 3'd6;
  localparam logic [2:0]       IDX_PRESC = 3'd7;
`ifdef PWM_LED_FADE_EN
  localparam logic [2:0]       IDX_STAT  = 3'd5;
`endif

  logic [WIDTH-1:0]   shadow [NCH];
  logic [WIDTH-1:0]   active [NCH];
  logic               en;
  logic               inv;
  logic [PRESC_W-1:0] presc;
  logic [PRESC_W-1:0] psc_cnt;
  logic [WIDTH-1:0]   cnt;
  logic [2:0]         idx;
  logic               aligned;
  logic               tick;
  logic               period_start;
  logic [NCH-1:0]     raw;
  logic [WIDTH-1:0]   rd_mux;

  assign idx     = addr[4:2];
  assign aligned = (addr[1:0] == 2'b00);
  // ">=" rather than "==" so a presc write below the running count wraps on the next cycle
  assign tick         = en && (psc_cnt >= presc);
  assign period_start = tick && (cnt == FULL);

  always_comb begin
    raw = '0;
    for (int i = 0; i < NCH; i++) begin
      raw[i] = (active[i] == FULL) || (cnt < active[i]);
    end
  end

`ifdef PWM_LED_FADE_EN
  logic [NCH-1:0] fading;
  always_comb begin
    fading = '0;
    for (int i = 0; i < NCH; i++) begin
      fading[i] = (active[i] != shadow[i]);
    end
  end
`endif

  always_comb begin
    rd_mux = '0;
    if (aligned) begin
      for (int i = 0; i < NCH; i++) begin
        if (idx == 3'(i)) rd_mux = shadow[i];
      end
`ifdef PWM_LED_FADE_EN
      if (idx == IDX_STAT) rd_mux = WIDTH'(fading);
`endif
      if (idx == IDX_CTRL)  rd_mux = {{(WIDTH-2){1'b0}}, inv, en};
      if (idx == IDX_PRESC) rd_mux = WIDTH'(presc);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < NCH; i++) shadow[i] <= '0;
      en       <= 1'b1;
      inv      <= 1'b0;
      presc    <= '0;
      rd_data  <= '0;
      rd_valid <= 1'b0;
    end else begin
      rd_valid <= rd_en;
      if (rd_en) rd_data <= rd_mux;
      if (wr_en && aligned) begin
        for (int i = 0; i < NCH; i++) begin
          if (idx == 3'(i)) shadow[i] <= wr_data;
        end
        if (idx == IDX_CTRL) begin
          en  <= wr_data[0];
          inv <= wr_data[1];
        end
        if (idx == IDX_PRESC) presc <= PRESC_W'(wr_data);
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      psc_cnt <= '0;
      cnt     <= '0;
    end else if (tick) begin
      psc_cnt <= '0;
      cnt     <= cnt + WIDTH'(1);
    end else if (en) begin
      psc_cnt <= psc_cnt + PRESC_W'(1);
    end
  end

  // Shadow write and period start on the same edge: the old shadow is taken here
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < NCH; i++) active[i] <= '0;
    end else if (period_start) begin
      for (int i = 0; i < NCH; i++) begin
`ifdef PWM_LED_FADE_EN
        if (active[i] < shadow[i])      active[i] <= active[i] + WIDTH'(1);
        else if (active[i] > shadow[i]) active[i] <= active[i] - WIDTH'(1);
`else
        active[i] <= shadow[i];
`endif
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) led <= '0;
    else        led <= en ? (raw ^ {NCH{inv}}) : {NCH{inv}};
  end

endmodule

// File: tb/tb_pwm_led_bank.sv
// tb_pwm_led_bank: register table, directed PWM/prescaler/ctrl sequences and randomized traffic
// checked every cycle against a cycle-level reference of the PWM rules.
module tb_pwm_led_bank;
  localparam int NCH     = 3;
  localparam int WIDTH   = 8;
  localparam int PRESC_W = 8;
  localparam int FULL    = (1 << WIDTH) - 1;

  logic             clk = 1'b0;
  logic             rst_n = 1'b0;
  logic             rd_en = 1'b0;
  logic             wr_en = 1'b0;
  logic [4:0]       addr = '0;
  logic [WIDTH-1:0] wr_data = '0;
  logic [WIDTH-1:0] rd_data;
  logic             rd_valid;
  logic [NCH-1:0]   led;

  pwm_led_bank #(.NCH(NCH), .WIDTH(WIDTH), .PRESC_W(PRESC_W)) dut (
    .clk(clk), .rst_n(rst_n), .rd_en(rd_en), .addr(addr), .rd_data(rd_data),
    .rd_valid(rd_valid), .wr_en(wr_en), .wr_data(wr_data), .led(led)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;
  int cyc = 0;
  int hi_cnt [NCH];
  logic [NCH-1:0] led_prev;
  logic [NCH-1:0] rise;

  // reference state
  int m_shadow [NCH];
  int m_active [NCH];
  int m_en, m_inv, m_presc, m_phase, m_cnt, m_rd_data, m_rd_valid;
  int m_led;

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  function automatic void model_reset();
    for (int i = 0; i < NCH; i++) begin
      m_shadow[i] = 0;
      m_active[i] = 0;
    end
    m_en = 1; m_inv = 0; m_presc = 0; m_phase = 0; m_cnt = 0;
    m_rd_data = 0; m_rd_valid = 0; m_led = 0;
  endfunction

  function automatic int model_read(input int a);
    int k;
    if (a % 4 != 0) return 0;
    k = a / 4;
    if (k < NCH) return m_shadow[k];
    if (a == 24) return m_en + 2 * m_inv;
    if (a == 28) return m_presc % (1 << WIDTH);
`ifdef PWM_LED_FADE_EN
    if (a == 20) begin
      int mask = 0;
      for (int i = 0; i < NCH; i++) if (m_active[i] != m_shadow[i]) mask += (1 << i);
      return mask;
    end
`endif
    return 0;
  endfunction

  function automatic void model_step(input bit we, input bit re, input int a, input int wd);
    int nl = 0;
    for (int i = 0; i < NCH; i++) begin
      int r = ((m_active[i] == FULL) || (m_cnt < m_active[i])) ? 1 : 0;
      if (m_en != 0) r = r ^ m_inv;
      else           r = m_inv;
      nl += r << i;
    end
    if (re) begin
      m_rd_data  = model_read(a);
      m_rd_valid = 1;
    end else begin
      m_rd_valid = 0;
    end
    if (m_en != 0) begin
      if (m_phase >= m_presc) begin
        m_phase = 0;
        m_cnt = (m_cnt + 1) % (FULL + 1);
        if (m_cnt == 0) begin
          for (int i = 0; i < NCH; i++) begin
`ifdef PWM_LED_FADE_EN
            if (m_active[i] < m_shadow[i])      m_active[i]++;
            else if (m_active[i] > m_shadow[i]) m_active[i]--;
`else
            m_active[i] = m_shadow[i];
`endif
          end
        end
      end else begin
        m_phase++;
      end
    end
    m_led = nl;
    if (we && (a % 4 == 0)) begin
      if (a / 4 < NCH) m_shadow[a / 4] = wd;
      else if (a == 24) begin
        m_en  = wd & 1;
        m_inv = (wd >> 1) & 1;
      end else if (a == 28) m_presc = wd % (1 << PRESC_W);
    end
  endfunction

  // One clock: drive inputs, step the reference at the edge, compare 1 time unit later.
  task automatic cycle(input bit we, input bit re, input int a, input int wd);
    wr_en = we; rd_en = re; addr = a[4:0]; wr_data = wd[WIDTH-1:0];
    @(posedge clk);
    model_step(we, re, a, wd);
    #1;
    cyc++;
    chk($sformatf("led@%0d", cyc), int'(led), m_led);
    chk($sformatf("rd_valid@%0d", cyc), int'(rd_valid), m_rd_valid);
    chk($sformatf("rd_data@%0d", cyc), int'(rd_data), m_rd_data);
    for (int i = 0; i < NCH; i++) begin
      if (led[i]) hi_cnt[i]++;
      rise[i] = !led_prev[i] && led[i];
    end
    led_prev = led;
    wr_en = 1'b0; rd_en = 1'b0;
  endtask

  task automatic wr(input int a, input int d);
    cycle(1, 0, a, d);
  endtask

  task automatic rd(input int a);
    cycle(0, 1, a, 0);
  endtask

  task automatic idle(input int n);
    for (int k = 0; k < n; k++) cycle(0, 0, 0, 0);
  endtask

  task automatic wait_rise(input int ch, input string name);
    bit found;
    found = 1'b0;
    for (int k = 0; k < 3000 && !found; k++) begin
      cycle(0, 0, 0, 0);
      if (rise[ch]) found = 1'b1;
    end
    chk(name, int'(found), 1);
  endtask

  // Called right after a rising edge of led[ch]; measures that period up to the next rise.
  task automatic period_from_rise(input int ch, input string name, output int highs, output int len);
    int sh, sc;
    sh = hi_cnt[ch] - 1;
    sc = cyc - 1;
    wait_rise(ch, name);
    highs = (hi_cnt[ch] - 1) - sh;
    len   = (cyc - 1) - sc;
  endtask

  task automatic count_highs(input int ch, input int n, output int h);
    int h0;
    h0 = hi_cnt[ch];
    idle(n);
    h = hi_cnt[ch] - h0;
  endtask

  task automatic do_reset();
    #2;
    rst_n = 1'b0;
    #1;
    chk("async_reset_led", int'(led), 0);
    chk("async_reset_rd_valid", int'(rd_valid), 0);
    chk("async_reset_rd_data", int'(rd_data), 0);
    @(posedge clk);
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    model_reset();
    led_prev = '0;
    rise = '0;
  endtask

  typedef struct packed {
    logic             we;
    logic [4:0]       a;
    logic [WIDTH-1:0] wd;
    logic [WIDTH-1:0] exp;
  } vec_t;

  localparam int NV = 18;
  vec_t vecs [NV];

  initial begin
    #5_000_000;
    $display("FAIL watchdog: simulation did not finish within time limit");
    $fatal(1, "watchdog");
  end

  initial begin
    int h, l, hb, lb, sh, sc;

    vecs[0]  = '{1'b0, 5'h00, 8'h00, 8'h00};
    vecs[1]  = '{1'b0, 5'h04, 8'h00, 8'h00};
    vecs[2]  = '{1'b0, 5'h08, 8'h00, 8'h00};
    vecs[3]  = '{1'b0, 5'h18, 8'h00, 8'h01};
    vecs[4]  = '{1'b0, 5'h1C, 8'h00, 8'h00};
    vecs[5]  = '{1'b1, 5'h00, 8'h5A, 8'h5A};
    vecs[6]  = '{1'b1, 5'h08, 8'hC3, 8'hC3};
    vecs[7]  = '{1'b1, 5'h10, 8'h33, 8'h00};
    vecs[8]  = '{1'b1, 5'h0C, 8'h77, 8'h00};
`ifdef PWM_LED_FADE_EN
    vecs[9]  = '{1'b1, 5'h14, 8'h11, 8'h05};
`else
    vecs[9]  = '{1'b1, 5'h14, 8'h11, 8'h00};
`endif
    vecs[10] = '{1'b1, 5'h18, 8'hFE, 8'h02};
    vecs[11] = '{1'b1, 5'h18, 8'h01, 8'h01};
    vecs[12] = '{1'b1, 5'h1C, 8'h02, 8'h02};
    vecs[13] = '{1'b1, 5'h1C, 8'h00, 8'h00};
    vecs[14] = '{1'b0, 5'h01, 8'h00, 8'h00};
    vecs[15] = '{1'b1, 5'h05, 8'h99, 8'h00};
    vecs[16] = '{1'b0, 5'h04, 8'h00, 8'h00};
    vecs[17] = '{1'b1, 5'h04, 8'h21, 8'h21};

    for (int i = 0; i < NCH; i++) hi_cnt[i] = 0;
    led_prev = '0;
    rise = '0;
    model_reset();
    @(posedge clk);
    #1;
    do_reset();

    // reset asserted mid-period with a live duty
    wr(0, 8'h80);
    wait_rise(0, "pre_reset_rise");
`ifndef PWM_LED_FADE_EN
    idle(40);
`endif
    chk("pre_reset_led0", int'(led[0]), 1);
    do_reset();

    // register table: reset values, write/readback, unmapped and unaligned
    for (int i = 0; i < NV; i++) begin
      if (vecs[i].we) wr(int'(vecs[i].a), int'(vecs[i].wd));
      rd(int'(vecs[i].a));
      chk($sformatf("table%0d_rd_data", i), int'(rd_data), int'(vecs[i].exp));
      chk($sformatf("table%0d_rd_valid", i), int'(rd_valid), 1);
    end

    // rd_valid is a single-cycle pulse and rd_data holds
    rd(24);
    chk("pulse_valid_hi", int'(rd_valid), 1);
    chk("pulse_data", int'(rd_data), 1);
    idle(1);
    chk("pulse_valid_lo", int'(rd_valid), 0);
    chk("pulse_data_hold", int'(rd_data), 1);

    // same-cycle read and write to one address returns the old value
    wr(0, 8'h11);
    cycle(1, 1, 0, 8'h22);
    chk("rw_same_old", int'(rd_data), 8'h11);
    rd(0);
    chk("rw_same_new", int'(rd_data), 8'h22);

`ifndef PWM_LED_FADE_EN
    wr(0, 0); wr(4, 0); wr(8, 0);

    // basic PWM duty cycles over a full 256-cycle window
    wr(0, 8'h40); idle(520); count_highs(0, 256, h); chk("duty40_highs", h, 64);
    wr(0, 8'h00); idle(520); count_highs(0, 256, h); chk("duty00_highs", h, 0);
    wr(0, 8'hFF); idle(520); count_highs(0, 256, h); chk("dutyFF_highs", h, 256);
    wr(0, 8'hFE); idle(520); count_highs(0, 256, h); chk("dutyFE_highs", h, 254);

    // prescaler 3 stretches the period to 1024 cycles
    wr(28, 3); wr(4, 8'h80); idle(2100);
    wait_rise(1, "presc_rise0");
    period_from_rise(1, "presc_rise1", h, l);
    chk("presc_highs", h, 512);
    chk("presc_len", l, 1024);
    wr(28, 0); wr(4, 0);

    // duty change mid-period only applies from the next period start
    wr(0, 8'h40); idle(520);
    wait_rise(0, "glitch_rise0");
    sh = hi_cnt[0] - 1;
    sc = cyc - 1;
    idle(31);
    wr(0, 8'h10);
    rd(0);
    chk("glitch_readback", int'(rd_data), 8'h10);
    wait_rise(0, "glitch_rise1");
    hb = (hi_cnt[0] - 1) - sh;
    lb = (cyc - 1) - sc;
    chk("glitch_cur_highs", hb, 64);
    chk("glitch_cur_len", lb, 256);
    period_from_rise(0, "glitch_rise2", h, l);
    chk("glitch_next_highs", h, 16);
    chk("glitch_next_len", l, 256);

    // inversion, disable and resume
    wr(0, 8'h40); idle(520);
    wr(24, 3); idle(4);
    count_highs(0, 256, h);
    chk("inv_highs", h, 192);
    wr(24, 2); idle(2);
    chk("disabled_led_inv", int'(led), (1 << NCH) - 1);
    idle(30);
    chk("disabled_led_hold", int'(led), (1 << NCH) - 1);
    wr(24, 1);
    wait_rise(0, "freeze_rise0");
    sh = hi_cnt[0] - 1;
    sc = cyc - 1;
    idle(100);
    wr(24, 0);
    idle(49);
    wr(24, 1);
    wait_rise(0, "freeze_rise1");
    chk("freeze_period_len", (cyc - 1) - sc, 306);
    chk("freeze_period_highs", (hi_cnt[0] - 1) - sh, 64);
`endif

    // randomized register traffic against the reference
    for (int n = 0; n < 4000; n++) begin
      int r, a, d, pick;
      r = $urandom_range(0, 99);
      a = 4 * $urandom_range(0, 7);
      if ($urandom_range(0, 15) == 0) a = $urandom_range(0, 31);
      pick = $urandom_range(0, 4);
      if (a == 24)      d = (($urandom_range(0, 7) != 0) ? 1 : 0) + 2 * $urandom_range(0, 1);
      else if (a == 28) d = $urandom_range(0, 3);
      else if (pick == 0) d = 0;
      else if (pick == 1) d = FULL;
      else if (pick == 2) d = FULL - 1;
      else d = $urandom_range(0, FULL);
      if (r < 8)       cycle(1, $urandom_range(0, 3) == 0, a, d);
      else if (r < 30) cycle(0, 1, a, 0);
      else             cycle(0, 0, 0, 0);
    end

`ifdef PWM_LED_FADE_EN
    // fading: one duty step per period, status mask clears when target reached
    do_reset();
    wr(0, 4);
    rd(20);
    chk("fade_mask_start", int'(rd_data), 1);
    wait_rise(0, "fade_rise0");
    for (int k = 1; k <= 4; k++) begin
      period_from_rise(0, $sformatf("fade_rise%0d", k), h, l);
      chk($sformatf("fade_highs_p%0d", k), h, k);
    end
    rd(20);
    chk("fade_mask_done", int'(rd_data), 0);
`endif

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
